// File: rtl/cdc_pkg.sv
// Shared sizing for the write-side CDC queue: default dimensions and pointer width helper.
package cdc_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CNT_W = 16;

  // One extra bit beyond the address so full and empty stay distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cdc_tx_queue.sv
// DEPTH-word queue feeding a toggle-handshake CDC; one-cycle m_valid pulses, earliest 1 cycle after push.
// Backpressure: s_ready drops when full or flushing; a pop in the same cycle never frees a full slot.
module cdc_tx_queue
  import cdc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     w_clk,
  input  logic                     w_reset_n,
  input  logic [WIDTH-1:0]         s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     flush,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         sent_cnt
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int ADDR  = PTR_W - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR] != rd_ptr[ADDR]) &&
                 (wr_ptr[ADDR-1:0] == rd_ptr[ADDR-1:0]);

  assign s_ready = !full && !flush;
  // m_ready is a registered compare inside the CDC, so this path stays short.
  assign m_valid = !empty && m_ready && !flush;
  assign m_data  = mem[rd_ptr[ADDR-1:0]];
  assign level   = wr_ptr - rd_ptr;

  assign push = s_valid && s_ready;
  assign pop  = m_valid;

  always_ff @(posedge w_clk or negedge w_reset_n) begin
    if (!w_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr[ADDR-1:0]] <= s_data;
    end
  end

  always_ff @(posedge w_clk or negedge w_reset_n) begin
    if (!w_reset_n) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Flush discards everything not yet handed over by snapping the head to the tail.
  always_ff @(posedge w_clk or negedge w_reset_n) begin
    if (!w_reset_n) begin
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge w_clk or negedge w_reset_n) begin
    if (!w_reset_n) begin
      sent_cnt <= '0;
    end else if (pop && (sent_cnt != '1)) begin
      sent_cnt <= sent_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cdc_tx_queue.sv
// Randomised scoreboard bench for cdc_tx_queue with a slow toggle-handshake CDC model.
module tb_cdc_tx_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             w_clk;
  logic             w_reset_n;
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic             flush;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] sent_cnt;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] model_q[$];
  int               model_sent;
  int               pulse_cnt = 0;
  int               busy = 0;
  logic             cdc_en = 0;
  logic             rand_gap = 0;

  cdc_tx_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .w_clk    (w_clk),
    .w_reset_n(w_reset_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .flush    (flush),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .level    (level),
    .sent_cnt (sent_cnt)
  );

  initial w_clk = 0;
  always #5 w_clk = ~w_clk;

  // CDC ready is low while a handshake round-trip is in flight.
  assign m_ready = cdc_en && (busy == 0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // CDC model: after each accepted pulse, ready stays low for a round-trip.
  initial begin
    int last;
    last = 0;
    forever begin
      @(posedge w_clk);
      #1;
      if (pulse_cnt != last) begin
        last = pulse_cnt;
        busy = rand_gap ? int'($urandom_range(1, 4)) : 5;
      end else if (busy > 0) begin
        busy--;
      end
    end
  end

  // Monitor / scoreboard: reference queue of accepted words, checked at every negedge.
  initial begin
    logic exp_sr;
    logic exp_mv;
    logic prev_mv;
    prev_mv = 0;
    model_sent = 0;
    forever begin
      @(negedge w_clk or negedge w_reset_n);
      if (!w_reset_n) begin
        model_q.delete();
        model_sent = 0;
        prev_mv = 0;
        #1;
        if (!w_reset_n) begin
          chk("rst_s_ready", 64'(s_ready), 64'd1);
          chk("rst_m_valid", 64'(m_valid), 64'd0);
          chk("rst_level", 64'(level), 64'd0);
          chk("rst_sent_cnt", 64'(sent_cnt), 64'd0);
          chk("rst_m_data", 64'(m_data), 64'd0);
        end
      end else begin
        exp_sr = (model_q.size() < DEPTH) && !flush;
        exp_mv = (model_q.size() > 0) && m_ready && !flush;
        chk("s_ready", 64'(s_ready), 64'(exp_sr));
        chk("m_valid", 64'(m_valid), 64'(exp_mv));
        chk("level", 64'(level), 64'(model_q.size()));
        chk("sent_cnt", 64'(sent_cnt), 64'(model_sent));
        chk("pulse_width", 64'(prev_mv && m_valid), 64'd0);
        prev_mv = m_valid;
        if (m_valid) pulse_cnt++;
        if (exp_mv) begin
          chk("m_data", 64'(m_data), 64'(model_q[0]));
          void'(model_q.pop_front());
          if (model_sent < (1 << CNT_W) - 1) model_sent++;
        end
        if (s_valid && exp_sr) model_q.push_back(s_data);
        if (flush) model_q.delete();
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge w_clk);
      #1;
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    logic acc;
    logic done;
    done = 0;
    s_valid = 1;
    s_data  = d;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge w_clk);
      acc = s_ready;
      @(posedge w_clk);
      #1;
      done = acc;
    end
    s_valid = 0;
    chk("push_accepted", 64'(done), 64'd1);
  endtask

  task automatic wait_idle();
    logic done;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (level == 0) done = 1;
      else cyc(1);
    end
    chk("drain_done", 64'(done), 64'd1);
    cyc(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    w_reset_n = 1;
    s_valid   = 0;
    s_data    = '0;
    flush     = 0;
    #2 w_reset_n = 0;
    #30 w_reset_n = 1;
    cyc(2);

    // Single word through an idle CDC.
    cdc_en = 1;
    push(32'hDEADBEEF);
    wait_idle();
    chk("single_sent", 64'(sent_cnt), 64'd1);

    // Fill with CDC stalled, ninth word held by producer.
    cdc_en = 0;
    for (int i = 1; i <= 8; i++) push(WIDTH'(i));
    s_valid = 1;
    s_data  = 32'd9;
    cyc(3);
    chk("fill_level", 64'(level), 64'd8);
    chk("fill_s_ready", 64'(s_ready), 64'd0);
    cdc_en = 1;
    push(32'd9);
    wait_idle();
    chk("fill_sent", 64'(sent_cnt), 64'd10);

    // Wrap-around with random CDC round-trip and producer gaps.
    rand_gap = 1;
    for (int i = 0; i < 20; i++) begin
      push($urandom);
      cyc($urandom_range(0, 2));
    end
    wait_idle();
    chk("wrap_sent", 64'(sent_cnt), 64'd30);

    // Flush with five words queued.
    cdc_en = 0;
    for (int i = 0; i < 5; i++) push($urandom);
    chk("pre_flush_level", 64'(level), 64'd5);
    flush = 1;
    cyc(1);
    flush = 0;
    chk("post_flush_level", 64'(level), 64'd0);
    chk("post_flush_m_valid", 64'(m_valid), 64'd0);
    chk("post_flush_sent", 64'(sent_cnt), 64'd30);
    cdc_en = 1;
    push(32'hA5);
    wait_idle();
    chk("flush_then_sent", 64'(sent_cnt), 64'd31);

    // Asynchronous reset between edges with four words queued.
    cdc_en = 0;
    for (int i = 0; i < 4; i++) push($urandom);
    chk("pre_reset_level", 64'(level), 64'd4);
    #2 w_reset_n = 0;
    #4 w_reset_n = 1;
    cyc(1);
    cdc_en = 1;
    push(32'h42);
    wait_idle();
    chk("reset_then_sent", 64'(sent_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
